mulmx_dot_unit: RTL and testbench
=================================

Name: mulmx_dot_unit

Overview:
Datapath stage directly downstream of the matrix-multiply controller. Each enabled cycle it takes one row of A and one column of Binv as four element pairs, plus the result address. It computes their fixed-point dot product in a 3-stage pipeline and writes the result into an internal 16-entry MxR result buffer. It pulses a completion flag once the controller's last element has been written.

Parameters:
DW, 16, signed element width (two's complement fixed point)
FRAC, 8, fractional bits (Q(DW-FRAC).FRAC format, 1.0 = 0x0100 at defaults)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
enMulmx  input  1  element valid from controller; inputs sampled only when high
doneMulmx  input  1  marks the last element of a job; qualified by enMulmx
addrMxR  input  4  result address; ignored (may be Z) when enMulmx low
a0..a3  input  DW each  A row elements (signed)
b0..b3  input  DW each  Binv column elements (signed)
rd_addr  input  4  result buffer read address
rd_data  output  DW  result buffer read data, combinational from rd_addr
wr_en  output  1  pulse when a result is written
wr_addr  output  4  address of the result being written
wr_data  output  DW  result being written
busy  output  1  any pipeline stage holds a valid element
done_out  output  1  one-cycle pulse after the last element is committed
ovf  output  1  sticky overflow flag for the current job

Behaviour:
- Reset is synchronous: when rst_n is low at a rising edge, all pipeline valid bits, wr_en, done_out and ovf go to 0. wr_addr and wr_data go to 0. The result buffer is not cleared.
- Reset mid-job: in-flight elements are discarded, with no write and no done_out. busy is 0 in the cycle after the reset edge.
- Stage 1 (edge k, enMulmx=1): register p_i = a_i*b_i as signed 2*DW values. Register addr, last = doneMulmx and valid=1. When enMulmx=0, valid=0 and other inputs are don't-care; X/Z values must not reach registers that are observed.
- Stage 2 (edge k+1): s01 = p0+p1 and s23 = p2+p3, each 2*DW+1 bits, sign-extended.
- Stage 3 (edge k+2): sum = s01+s23 (2*DW+2 bits). Then r = (sum + 2^(FRAC-1)) >>> FRAC, an arithmetic shift giving round-half-up. r is narrowed to DW as described under Optional Feature.
- At edge k+2: wr_en=1, wr_addr=addr, wr_data=result. The buffer entry mem[addr] is written at edge k+3. wr_en stays high for exactly one cycle per element.
- Latency: input sampled at edge k, wr_en/wr_data visible in the cycle after edge k+2, rd_data updated after edge k+3.
- Throughput: one element per cycle, fully pipelined, no stall. Back-to-back elements and gaps in enMulmx are both legal.
- done_out: registered one cycle after the write of the element tagged last. It is high in the cycle after edge k+3, when the buffer already holds the final result.
- busy = OR of the three stage valid bits.
- ovf: cleared when an element is accepted while busy=0 and done_out=0 (job start). Set when any element of the job saturates. Held until the next job start or reset.
- Repeated addresses: the last write wins.
- A new job may start while the previous one drains. ovf is not cleared in that case.

Optional Feature:
MULMX_SAT_EN
- Defined: a value r outside [-2^(DW-1), 2^(DW-1)-1] is clamped to the nearest bound, and ovf is set.
- Undefined: the result is truncated to r[DW-1:0] (wrap-around), and ovf is tied to 0.

Test Plan:
1. Single element: A=[0x0100,0,0,0], B=[0x0300,5,6,7], addr=4 -> wr_en pulse three cycles later with wr_addr=4, wr_data=0x0300. mem[4]=0x0300.
2. Full 16-cycle job, A=identity, Binv=B with arbitrary values (controller-ordered addresses 0..15, doneMulmx on the 16th) -> mem[i]=B[i] for all i. done_out pulses exactly once, one cycle after the 16th wr_en. busy then falls.
3. Rounding: a0=0x0001, b0=0x0080, others 0 -> wr_data=0x0001. a0=0xFFFF, b0=0x0080 -> wr_data=0x0000.
4. Overflow: all a_i=b_i=0x7FFF -> wr_data=0x7FFF and ovf=1 with MULMX_SAT_EN; wr_data=0xFC00 and ovf=0 without it. The next job start clears ovf.
5. Gaps and Z: drive enMulmx low for 3 cycles mid-job with addrMxR=Z -> no wr_en during the gap, and remaining results are correct.
6. Reset mid-job: drop rst_n for one edge at the 6th element -> no wr_en after the reset edge, done_out never pulses, busy=0, ovf=0. Earlier buffer entries are unchanged.

Source files
------------

// File: rtl/mulmx_dot_unit.sv
// mulmx_dot_unit: 3-stage 4-term fixed-point dot product feeding a 16-entry result buffer.
// Define MULMX_SAT_EN to clamp out-of-range results and report them on ovf; otherwise results wrap and ovf is 0.
module mulmx_dot_unit #(
  parameter int DW   = 16,
  parameter int FRAC = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enMulmx,
  input  logic                 doneMulmx,
  input  logic [3:0]           addrMxR,
  input  logic signed [DW-1:0] a0,
  input  logic signed [DW-1:0] a1,
  input  logic signed [DW-1:0] a2,
  input  logic signed [DW-1:0] a3,
  input  logic signed [DW-1:0] b0,
  input  logic signed [DW-1:0] b1,
  input  logic signed [DW-1:0] b2,
  input  logic signed [DW-1:0] b3,
  input  logic [3:0]           rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 wr_en,
  output logic [3:0]           wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic                 busy,
  output logic                 done_out,
  output logic                 ovf
);
  localparam int PW = 2*DW;
  localparam int SW = 2*DW + 2;
  localparam int RW = SW - FRAC;
  localparam logic signed [SW-1:0] HALF = SW'(1) <<< (FRAC-1);

  logic signed [DW-1:0] a_vec [4];
  logic signed [DW-1:0] b_vec [4];
  logic signed [PW-1:0] p_d   [4];
  logic signed [PW-1:0] p_q   [4];
  logic                 v1_q, last1_q;
  logic [3:0]           addr1_q;

  assign a_vec[0] = a0;
  assign a_vec[1] = a1;
  assign a_vec[2] = a2;
  assign a_vec[3] = a3;
  assign b_vec[0] = b0;
  assign b_vec[1] = b1;
  assign b_vec[2] = b2;
  assign b_vec[3] = b3;

  // Data registers only load on a valid element so undriven inputs never enter the pipe.
  for (genvar gi = 0; gi < 4; gi++) begin : g_prod
    assign p_d[gi] = PW'(a_vec[gi]) * PW'(b_vec[gi]);
    always_ff @(posedge clk) begin
      if (enMulmx) p_q[gi] <= p_d[gi];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) v1_q <= 1'b0;
    else        v1_q <= enMulmx;
    if (enMulmx) begin
      addr1_q <= addrMxR;
      last1_q <= doneMulmx;
    end
  end

  logic signed [PW:0] s01_d, s23_d, s01_q, s23_q;
  logic               v2_q, last2_q;
  logic [3:0]         addr2_q;

  assign s01_d = (PW+1)'(p_q[0]) + (PW+1)'(p_q[1]);
  assign s23_d = (PW+1)'(p_q[2]) + (PW+1)'(p_q[3]);

  always_ff @(posedge clk) begin
    if (!rst_n) v2_q <= 1'b0;
    else        v2_q <= v1_q;
    if (v1_q) begin
      s01_q   <= s01_d;
      s23_q   <= s23_d;
      addr2_q <= addr1_q;
      last2_q <= last1_q;
    end
  end

  logic signed [SW-1:0] sum_d, rnd_d;
  logic signed [RW-1:0] r_d;
  logic [DW-1:0]        res_d;
  logic                 unused_frac;

  assign sum_d = SW'(s01_q) + SW'(s23_q);
  assign rnd_d = sum_d + HALF;
  // Dropping the low FRAC bits of the rounded sum is the arithmetic right shift.
  assign r_d   = rnd_d[SW-1:FRAC];
  assign unused_frac = ^rnd_d[FRAC-1:0];

`ifdef MULMX_SAT_EN
  logic sat_hi, sat_lo;
  assign sat_hi = ~r_d[RW-1] & (|r_d[RW-2:DW-1]);
  assign sat_lo =  r_d[RW-1] & ~(&r_d[RW-2:DW-1]);

  always_comb begin
    res_d = r_d[DW-1:0];
    if (sat_hi)      res_d = {1'b0, {(DW-1){1'b1}}};
    else if (sat_lo) res_d = {1'b1, {(DW-1){1'b0}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^r_d[RW-1:DW];
  assign res_d     = r_d[DW-1:0];
`endif

  logic          wr_en_q, last3_q, done_q;
  logic [3:0]    wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [DW-1:0] mem_q [16];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      last3_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= v2_q;
      last3_q <= v2_q & last2_q;
      done_q  <= wr_en_q & last3_q;
      if (v2_q) begin
        wr_addr_q <= addr2_q;
        wr_data_q <= res_d;
      end
    end
  end

  // A commit that coincides with a reset edge belongs to a discarded job.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_q) mem_q[wr_addr_q] <= wr_data_q;
  end

  assign rd_data  = mem_q[rd_addr];
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = v1_q | v2_q | wr_en_q;
  assign done_out = done_q;

`ifdef MULMX_SAT_EN
  logic ovf_q, job_start;
  assign job_start = enMulmx & ~busy & ~done_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                       ovf_q <= 1'b0;
    else if (job_start)               ovf_q <= 1'b0;
    else if (v2_q & (sat_hi | sat_lo)) ovf_q <= 1'b1;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mulmx_dot_unit.sv
// Directed bench for mulmx_dot_unit: single element, rounding, overflow, full job, gaps with Z, reset mid-job.
module tb_mulmx_dot_unit;
  logic        clk = 1'b0;
  logic        rst_n, enMulmx, doneMulmx;
  logic [3:0]  addrMxR, rd_addr, wr_addr;
  logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic [15:0] rd_data, wr_data;
  logic        wr_en, busy, done_out, ovf;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_mem [16];
  logic [15:0] exp_known = '0;

`ifdef MULMX_SAT_EN
  localparam logic [15:0] OVF_DATA = 16'h7FFF;
  localparam logic        OVF_FLAG = 1'b1;
`else
  localparam logic [15:0] OVF_DATA = 16'hFC00;
  localparam logic        OVF_FLAG = 1'b0;
`endif

  always #5 clk = ~clk;

  mulmx_dot_unit dut (
    .clk(clk), .rst_n(rst_n), .enMulmx(enMulmx), .doneMulmx(doneMulmx), .addrMxR(addrMxR),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done_out(done_out), .ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_elem(input logic [3:0] ad, input logic last,
                            input logic [15:0] xa0, xa1, xa2, xa3, xb0, xb1, xb2, xb3);
    enMulmx = 1'b1; doneMulmx = last; addrMxR = ad;
    a0 = xa0; a1 = xa1; a2 = xa2; a3 = xa3;
    b0 = xb0; b1 = xb1; b2 = xb2; b3 = xb3;
  endtask

  task automatic drive_idle();
    enMulmx = 1'b0; doneMulmx = 1'b0; addrMxR = 4'bzzzz;
    a0 = 'x; a1 = 'x; a2 = 'x; a3 = 'x;
    b0 = 'x; b1 = 'x; b2 = 'x; b3 = 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_addr = '0;
    drive_idle();
    tick(); tick();
    checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_out); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (wr_addr !== 4'h0)  begin errors++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    checks++; if (wr_data !== 16'h0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    rst_n = 1'b1;
    $display("reset: outputs cleared");
  endtask

  task automatic test_single();
    drive_elem(4'd4, 1'b0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0300, 16'd5, 16'd6, 16'd7);
    tick();
    drive_idle();
    tick();
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL single_early_wr_en got=%b exp=0", wr_en); end
    tick();
    checks++; if (wr_en !== 1'b1)      begin errors++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
    checks++; if (wr_addr !== 4'd4)    begin errors++; $display("FAIL single_wr_addr got=%h exp=4", wr_addr); end
    checks++; if (wr_data !== 16'h0300) begin errors++; $display("FAIL single_wr_data got=%h exp=0300", wr_data); end
    tick();
    checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL single_pulse_len got=%b exp=0", wr_en); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL single_done got=%b exp=0", done_out); end
    rd_addr = 4'd4; #1;
    checks++; if (rd_data !== 16'h0300) begin errors++; $display("FAIL single_mem4 got=%h exp=0300", rd_data); end
    exp_mem[4] = 16'h0300; exp_known[4] = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", busy); end
    $display("single: addr=4 data=%h", wr_data);
  endtask

  task automatic test_rounding();
    drive_elem(4'd1, 1'b0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0, 16'h0, 16'h0);
    tick();
    drive_elem(4'd2, 1'b0, 16'hFFFF, 16'h0, 16'h0, 16'h0, 16'h0080, 16'h0, 16'h0, 16'h0);
    tick();
    drive_idle();
    tick();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd1 || wr_data !== 16'h0001)
      begin errors++; $display("FAIL round_half_pos got=%b/%h/%h exp=1/1/0001", wr_en, wr_addr, wr_data); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd2 || wr_data !== 16'h0000)
      begin errors++; $display("FAIL round_half_neg got=%b/%h/%h exp=1/2/0000", wr_en, wr_addr, wr_data); end
    tick(); tick();
    exp_mem[1] = 16'h0001; exp_mem[2] = 16'h0000; exp_known[2:1] = 2'b11;
    $display("rounding: +0.5 lsb -> 0001, -0.5 lsb -> 0000");
  endtask

  task automatic test_overflow();
    drive_elem(4'd5, 1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    tick();
    drive_idle();
    tick(); tick();
    checks++; if (wr_en !== 1'b1 || wr_data !== OVF_DATA)
      begin errors++; $display("FAIL ovf_data got=%b/%h exp=1/%h", wr_en, wr_data, OVF_DATA); end
    checks++; if (ovf !== OVF_FLAG) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", ovf, OVF_FLAG); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL ovf_drain_busy got=%b exp=0", busy); end
    checks++; if (ovf !== OVF_FLAG)  begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", ovf, OVF_FLAG); end
    drive_elem(4'd6, 1'b0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0, 16'h0);
    tick();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_job_clear got=%b exp=0", ovf); end
    drive_idle();
    tick(); tick(); tick();
    exp_mem[5] = OVF_DATA; exp_mem[6] = 16'h0001; exp_known[6:5] = 2'b11;
    $display("overflow: result=%h flag=%b", OVF_DATA, OVF_FLAG);
  endtask

  task automatic test_full_job();
    logic [15:0] bv [16];
    logic [15:0] la [4];
    logic [15:0] lb [4];
    bv = '{16'h0001, 16'h0123, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0A0A, 16'hF00D, 16'h1234,
           16'h0000, 16'h00FF, 16'hFF00, 16'h4321, 16'hBEEF, 16'h0042, 16'h7000, 16'h9000};
    for (int c = 0; c < 21; c++) begin
      if (c < 16) begin
        for (int k = 0; k < 4; k++) begin
          la[k] = 16'h0;
          lb[k] = 16'(c*7 + k + 1);
        end
        la[c%4] = 16'h0100;
        lb[c%4] = bv[c];
        drive_elem(4'(c), c == 15, la[0], la[1], la[2], la[3], lb[0], lb[1], lb[2], lb[3]);
      end else begin
        drive_idle();
      end
      tick();
      checks++; if (wr_en !== (c >= 2 && c < 18))
        begin errors++; $display("FAIL job_wr_en cyc=%0d got=%b", c, wr_en); end
      if (c >= 2 && c < 18) begin
        checks++; if (wr_addr !== 4'(c-2) || wr_data !== bv[c-2])
          begin errors++; $display("FAIL job_write cyc=%0d got=%h/%h exp=%h/%h", c, wr_addr, wr_data, 4'(c-2), bv[c-2]); end
      end
      checks++; if (done_out !== (c == 18))
        begin errors++; $display("FAIL job_done cyc=%0d got=%b", c, done_out); end
      checks++; if (busy !== (c <= 17))
        begin errors++; $display("FAIL job_busy cyc=%0d got=%b", c, busy); end
    end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL job_ovf got=%b exp=0", ovf); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++; if (rd_data !== bv[i])
        begin errors++; $display("FAIL job_mem addr=%0d got=%h exp=%h", i, rd_data, bv[i]); end
      exp_mem[i] = bv[i];
    end
    exp_known = '1;
    $display("full_job: 16 elements written, done pulsed");
  endtask

  task automatic test_gap_z();
    int elem_at [9];
    logic [15:0] vals [6];
    logic [15:0] expv [6];
    int e;
    elem_at = '{0, 1, 2, -1, -1, -1, 3, 4, 5};
    vals    = '{16'h0010, 16'hFFF0, 16'h1234, 16'h0001, 16'hFFFE, 16'h0100};
    expv    = '{16'h0012, 16'hFFF2, 16'h1236, 16'h0003, 16'h0000, 16'h0102};
    for (int c = 0; c < 13; c++) begin
      if (c < 9 && elem_at[c] >= 0)
        drive_elem(4'(8 + elem_at[c]), elem_at[c] == 5, 16'h0100, 16'h0080, 16'h0, 16'h0,
                   vals[elem_at[c]], 16'h0004, 16'h0, 16'h0);
      else
        drive_idle();
      tick();
      e = (c >= 2 && c < 11) ? elem_at[c-2] : -1;
      checks++; if (wr_en !== (e >= 0))
        begin errors++; $display("FAIL gap_wr_en cyc=%0d got=%b exp=%b", c, wr_en, e >= 0); end
      if (e >= 0) begin
        checks++; if (wr_addr !== 4'(8 + e) || wr_data !== expv[e])
          begin errors++; $display("FAIL gap_write cyc=%0d got=%h/%h exp=%h/%h", c, wr_addr, wr_data, 4'(8 + e), expv[e]); end
      end
      checks++; if (done_out !== (c == 11))
        begin errors++; $display("FAIL gap_done cyc=%0d got=%b", c, done_out); end
      if (c >= 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy cyc=%0d got=%b exp=0", c, busy); end
      end
    end
    for (int i = 0; i < 6; i++) exp_mem[8+i] = expv[i];
    $display("gap_z: 6 elements across a 3-cycle gap");
  endtask

  task automatic test_reset_mid_job();
    for (int c = 0; c < 10; c++) begin
      if (c <= 5)
        drive_elem(4'(c), 1'b0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0A00 + 16'(c), 16'h0, 16'h0, 16'h0);
      else
        drive_idle();
      rst_n = (c == 5) ? 1'b0 : 1'b1;
      tick();
      if (c >= 2 && c <= 4) begin
        checks++; if (wr_en !== 1'b1 || wr_data !== 16'h0A00 + 16'(c-2))
          begin errors++; $display("FAIL rmj_pre cyc=%0d got=%b/%h", c, wr_en, wr_data); end
      end
      if (c >= 5) begin
        checks++; if (wr_en !== 1'b0 || done_out !== 1'b0 || busy !== 1'b0 || ovf !== 1'b0)
          begin errors++; $display("FAIL rmj_post cyc=%0d got we=%b done=%b busy=%b ovf=%b exp=0", c, wr_en, done_out, busy, ovf); end
      end
    end
    rst_n = 1'b1;
    exp_mem[0] = 16'h0A00; exp_mem[1] = 16'h0A01; exp_known[2] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (exp_known[i]) begin
        rd_addr = 4'(i); #1;
        checks++; if (rd_data !== exp_mem[i])
          begin errors++; $display("FAIL rmj_mem addr=%0d got=%h exp=%h", i, rd_data, exp_mem[i]); end
      end
    end
    $display("reset_mid_job: pipeline flushed, buffer retained");
  endtask

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_overflow();
    test_full_job();
    test_gap_z();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
